// File: rtl/timer_arbiter.sv
// -----------------------------------------------------------------------------
// timer_arbiter
//
// Purpose:
//    One shared timer handed out to N_REQ requesters in round-robin order.
//    The winner's terminal count is latched when it is granted. The timer then
//    counts up on tick cycles and saturates at that limit. When the count
//    reaches the limit the owner receives a one-cycle done pulse and the timer
//    is released. If the owner drops its request before that, the grant is
//    aborted: the timer is released and no done is produced.
//
// Ports:
//    clk    - single clock, everything updates on its rising edge
//    clr_n  - synchronous active-low reset
//    req    - per-requester timeout request (N_REQ bits)
//    limit  - packed per-requester terminal counts, requester i at [i*WIDTH +: WIDTH]
//    tick   - count enable
//    grant  - registered one-hot current owner, zero when the timer is free
//    done   - registered one-cycle completion pulse on the owner's bit
//    busy   - high whenever grant is non-zero
//    count  - shared timer value
// -----------------------------------------------------------------------------
module timer_arbiter #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   clr_n,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] limit,
   input  logic                   tick,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       done,
   output logic                   busy,
   output logic [WIDTH-1:0]       count
);

   localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state, state_next;

   logic [IDXW-1:0]  owner, owner_next;
   logic [IDXW-1:0]  last_owner, last_next;
   logic [IDXW-1:0]  winner;
   logic             found;
   logic [WIDTH-1:0] lim_q, lim_next;
   logic [WIDTH-1:0] count_next;
   logic [N_REQ-1:0] grant_next, done_next;
   logic [WIDTH-1:0] lim_arr [N_REQ];
   logic             owner_req;
   logic             at_limit;

   // Unpack the flat limit bus so a requester's limit can be picked by index.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         lim_arr[i] = limit[i*WIDTH +: WIDTH];
      end
   end

   // Round-robin search. It starts just after the last owner and wraps, so the
   // last owner is always examined last.
   always_comb begin
      int j;
      logic [IDXW-1:0] cand;
      found  = 1'b0;
      winner = '0;
      j      = 0;
      cand   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(last_owner) + 1 + k;
         if (j >= N_REQ) begin
            j = j - N_REQ;
         end
         cand = IDXW'(j);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winner = cand;
         end
      end
   end

   assign owner_req = req[owner];
   assign at_limit  = (count == lim_q);

   // State register.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. An abort outranks completion when both happen in the
   // same cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (found) state_next = RUN;
         RUN: begin
            if (!owner_req) begin
               state_next = IDLE;
            end else if (at_limit) begin
               state_next = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output and datapath next values. grant and done are computed here and
   // registered below, so both outputs come straight from flops. Leaving RUN
   // clears grant on that same edge. As a result the done pulse never
   // overlaps grant.
   always_comb begin
      grant_next = grant;
      done_next  = '0;
      count_next = count;
      lim_next   = lim_q;
      owner_next = owner;
      last_next  = last_owner;
      case (state)
         IDLE: begin
            if (found) begin
               grant_next         = '0;
               grant_next[winner] = 1'b1;
               count_next         = '0;
               lim_next           = lim_arr[winner];
               owner_next         = winner;
            end
         end
         RUN: begin
            if (!owner_req) begin
               grant_next = '0;
               count_next = '0;
               last_next  = owner;
            end else if (at_limit) begin
               grant_next = '0;
               done_next  = grant;
               last_next  = owner;
            end else if (tick && (count < lim_q)) begin
               count_next = count + 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers. After reset, last_owner points at the top index so
   // that requester 0 has the highest priority.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         grant      <= '0;
         done       <= '0;
         count      <= '0;
         lim_q      <= '0;
         owner      <= '0;
         last_owner <= IDXW'(N_REQ - 1);
      end else begin
         grant      <= grant_next;
         done       <= done_next;
         count      <= count_next;
         lim_q      <= lim_next;
         owner      <= owner_next;
         last_owner <= last_next;
      end
   end

   assign busy = |grant;

endmodule

// File: tb/tb_timer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_timer_arbiter
//
// Self-checking bench for timer_arbiter (N_REQ=4, WIDTH=8). A transaction-
// level model tracks the owner, the count, the latched limit and the pending
// done pulse. The bench drives a set of directed scenarios, followed by
// randomized traffic. DUT outputs are compared every cycle at the falling edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_timer_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk;
   logic           clr_n_s;
   logic [N-1:0]   req_s;
   logic [N*W-1:0] limit_s;
   logic           tick_s;
   logic [N-1:0]   grant;
   logic [N-1:0]   done;
   logic           busy;
   logic [W-1:0]   count;

   int checks;
   int errors;

   // Reference model state: owner index (-1 when free), count, latched limit,
   // index of the requester whose done pulse is showing (-1 when none), and
   // the last owner used by round-robin.
   int m_owner;
   int m_cnt;
   int m_lim;
   int m_pulse;
   int m_last;

   timer_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
      .clk   (clk),
      .clr_n (clr_n_s),
      .req   (req_s),
      .limit (limit_s),
      .tick  (tick_s),
      .grant (grant),
      .done  (done),
      .busy  (busy),
      .count (count)
   );

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Every comparison goes through this task.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one clock edge. It uses the same inputs that the
   // DUT samples at that edge.
   task automatic modelEdge();
      if (!clr_n_s) begin
         m_owner = -1;
         m_cnt   = 0;
         m_lim   = 0;
         m_pulse = -1;
         m_last  = N - 1;
      end else if (m_pulse >= 0) begin
         m_pulse = -1;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int j;
            j = (m_last + k) % N;
            if (((req_s >> j) & 4'd1) != 4'd0) begin
               m_owner = j;
               m_cnt   = 0;
               m_lim   = int'(8'(limit_s >> (j * W)));
               break;
            end
         end
      end else if (((req_s >> m_owner) & 4'd1) == 4'd0) begin
         m_last  = m_owner;
         m_owner = -1;
         m_cnt   = 0;
      end else if (m_cnt == m_lim) begin
         m_pulse = m_owner;
         m_last  = m_owner;
         m_owner = -1;
      end else if (tick_s) begin
         m_cnt = m_cnt + 1;
      end
   endtask

   // One clock: the DUT and the model step together, and the outputs are then
   // compared half a cycle later.
   task automatic stepCycle();
      logic [N-1:0] exp_grant;
      logic [N-1:0] exp_done;
      @(posedge clk);
      modelEdge();
      @(negedge clk);
      exp_grant = (m_owner >= 0) ? N'(1 << m_owner) : '0;
      exp_done  = (m_pulse >= 0) ? N'(1 << m_pulse) : '0;
      checkOutput("grant", 32'(grant), 32'(exp_grant));
      checkOutput("done",  32'(done),  32'(exp_done));
      checkOutput("busy",  32'(busy),  32'(m_owner >= 0));
      checkOutput("count", 32'(count), 32'(m_cnt));
   endtask

   task automatic applyStimulus(input logic [N-1:0] r, input logic t, input logic c);
      req_s   = r;
      tick_s  = t;
      clr_n_s = c;
      stepCycle();
   endtask

   task automatic setLimit(input int idx, input int value);
      limit_s[idx*W +: W] = W'(value);
   endtask

   // Hold a request until the requester's done shows up or the budget runs
   // out. Returns the number of cycles since the request was first sampled.
   task automatic runUntilDone(input int idx, input int max_cycles, output int n);
      n = 0;
      do begin
         applyStimulus(N'(1 << idx), 1'b1, 1'b1);
         n++;
      end while (done[idx] !== 1'b1 && n < max_cycles);
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus('0, 1'b1, 1'b1);
   endtask

   initial begin
      int n;
      int seen;
      int order [5];
      logic [N-1:0] prev_grant;
      logic [N-1:0] r;

      checks  = 0;
      errors  = 0;
      m_owner = -1;
      m_cnt   = 0;
      m_lim   = 0;
      m_pulse = -1;
      m_last  = N - 1;
      req_s   = '0;
      tick_s  = 1'b0;
      limit_s = '0;
      clr_n_s = 1'b0;

      // Reset state.
      @(negedge clk);
      applyStimulus('0, 1'b0, 1'b0);
      applyStimulus('0, 1'b0, 1'b0);
      checkOutput("reset_grant", 32'(grant), 32'd0);
      checkOutput("reset_count", 32'(count), 32'd0);

      // Single requester, limit 5: done appears 7 cycles after req is sampled.
      setLimit(0, 5);
      runUntilDone(0, 20, n);
      checkOutput("latency_l5", 32'(n), 32'd7);
      checkOutput("final_count_l5", 32'(count), 32'd5);
      idleCycles(2);

      // Limit 0 completes without counting.
      setLimit(3, 0);
      runUntilDone(3, 20, n);
      checkOutput("latency_l0", 32'(n), 32'd2);
      idleCycles(2);

      // Contention with every limit at 2. After a reset, the grant order is 0,1,2,3,0.
      applyStimulus('0, 1'b1, 1'b0);
      for (int i = 0; i < N; i++) setLimit(i, 2);
      seen = 0;
      prev_grant = '0;
      for (int c = 0; c < 60 && seen < 5; c++) begin
         applyStimulus('1, 1'b1, 1'b1);
         if (grant != '0 && grant != prev_grant) begin
            for (int i = 0; i < N; i++) if (grant[i]) order[seen] = i;
            seen++;
         end
         prev_grant = grant;
      end
      checkOutput("contention_grants_seen", 32'(seen), 32'd5);
      for (int i = 0; i < 5; i++) checkOutput("contention_order", 32'(order[i]), 32'(i % N));
      idleCycles(3);

      // Gated tick with limit 3. The tick toggles 1,0,1,0 while requester 1 is granted.
      setLimit(1, 3);
      for (int c = 0; c < 14; c++) applyStimulus(4'b0010, 1'(c % 2 == 0), 1'b1);
      idleCycles(2);

      // Limit 255: the count stops at 255 and does not roll over.
      setLimit(2, 255);
      for (int c = 0; c < 262 && m_cnt < 255; c++) applyStimulus(4'b0100, 1'b1, 1'b1);
      checkOutput("sat_count_255", 32'(count), 32'd255);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("sat_abort_no_done", 32'(done), 32'd0);
      idleCycles(2);

      // Abort exactly when the count equals the limit: no done is produced.
      setLimit(1, 2);
      for (int c = 0; c < 20 && !(m_owner == 1 && m_cnt == 2); c++) applyStimulus(4'b0010, 1'b1, 1'b1);
      checkOutput("abort_at_limit_count", 32'(count), 32'd2);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("abort_at_limit_done", 32'(done), 32'd0);
      checkOutput("abort_at_limit_grant", 32'(grant), 32'd0);
      idleCycles(1);

      // Abort of requester 2 at count 2 with limit 6. The next winner is index 3.
      setLimit(2, 6);
      for (int c = 0; c < 20 && !(m_owner == 2 && m_cnt == 2); c++) applyStimulus(4'b0100, 1'b1, 1'b1);
      applyStimulus(4'b0000, 1'b1, 1'b1);
      checkOutput("abort_count_cleared", 32'(count), 32'd0);
      applyStimulus(4'b1001, 1'b1, 1'b1);
      checkOutput("abort_next_winner", 32'(grant), 32'b1000);
      idleCycles(3);

      // Reset at count 4 in the middle of a grant. Afterwards, index 0 wins first.
      setLimit(1, 6);
      for (int c = 0; c < 20 && !(m_owner == 1 && m_cnt == 4); c++) applyStimulus(4'b0010, 1'b1, 1'b1);
      applyStimulus(4'b0010, 1'b1, 1'b0);
      checkOutput("midrun_reset_busy", 32'(busy), 32'd0);
      checkOutput("midrun_reset_count", 32'(count), 32'd0);
      applyStimulus(4'b1111, 1'b1, 1'b1);
      checkOutput("post_reset_winner", 32'(grant), 32'b0001);
      idleCycles(4);

      // Randomized traffic. Requests rise at random and mostly hold until done.
      // Aborts, limit changes during grants and occasional resets are injected.
      r = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!r[i]) begin
               if ($urandom_range(0, 3) == 0) r[i] = 1'b1;
            end else if (m_pulse == i) begin
               if ($urandom_range(0, 1) == 0) r[i] = 1'b0;
            end else if ($urandom_range(0, 39) == 0) begin
               r[i] = 1'b0;
            end
         end
         if ($urandom_range(0, 3) == 0) begin
            setLimit(int'($urandom_range(0, N - 1)),
                     ($urandom_range(0, 49) == 0) ? 255 : int'($urandom_range(0, 6)));
         end
         applyStimulus(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 299) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/timer_arbiter.md
TIMER_ARBITER -- requirements
Module: timer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of requesters sharing the timer (2..8).
REQ-002 Parameter WIDTH, default 8, SHALL set the width of the timer count and of each limit.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port clr_n, input, 1, SHALL be the reset, synchronous and active-low.
REQ-005 Port req, input, N_REQ, SHALL be the per-requester timeout request, held high until done or abort.
REQ-006 Port limit, input, N_REQ*WIDTH, SHALL carry requester i's terminal count in bits [i*WIDTH +: WIDTH].
REQ-007 Port tick, input, 1, SHALL be the count enable; the timer advances only in cycles where tick=1.
REQ-008 Port grant, output, N_REQ, SHALL be the one-hot current owner, or all-zero when no owner.
REQ-009 Port done, output, N_REQ, SHALL pulse one cycle on the owner's bit at timeout completion.
REQ-010 Port busy, output, 1, SHALL be high whenever grant is non-zero.
REQ-011 Port count, output, WIDTH, SHALL expose the shared timer value.

Function
REQ-012 Control SHALL be a 3-state FSM: IDLE, RUN, DONE.
REQ-013 In IDLE with req non-zero, the block SHALL select a winner round-robin, starting at index (last_owner+1) mod N_REQ and searching upward with wrap.
REQ-014 On the IDLE->RUN transition, the block SHALL register grant, latch the winner's limit, and set count to 0; grant is visible the cycle after req is first sampled.
REQ-015 The latched limit SHALL NOT change for the remainder of the grant, regardless of the limit port.
REQ-016 In RUN with tick=1 and count < latched limit, count SHALL increment by 1.
REQ-017 count SHALL saturate at the latched limit and never roll over; tick=0 SHALL hold count.
REQ-018 In RUN with count == latched limit and the owner's req high, the next state SHALL be DONE.
REQ-019 Limit 0 SHALL complete without counting: RUN lasts one cycle, then DONE.
REQ-020 In RUN with the owner's req low (abort), the next state SHALL be IDLE: grant cleared, count cleared to 0, no done pulse, last_owner updated to the aborted owner.
REQ-021 When abort and count == limit occur in the same cycle, abort SHALL take priority.
REQ-022 In DONE, done[owner] SHALL be high for exactly that cycle and grant SHALL already be zero; last_owner updates to the owner; the next state is IDLE.
REQ-023 count SHALL hold its final value through DONE and IDLE until the next grant.
REQ-024 req changes of non-owners during RUN or DONE SHALL be ignored; arbitration occurs only in IDLE.
REQ-025 A requester still holding req after its done SHALL be re-arbitrated normally, with lowest priority.
REQ-026 With tick held at 1 and limit L, done SHALL assert L+2 cycles after the cycle req is first sampled in IDLE.
REQ-027 grant and done SHALL be registered outputs and always one-hot or zero.

Reset
REQ-028 With clr_n low at a clock edge, the block SHALL set: state IDLE, grant 0, done 0, busy 0, count 0, last_owner N_REQ-1 (index 0 highest priority).
REQ-029 Reset SHALL dominate all inputs, including mid-RUN and during a DONE pulse; no done is produced for the interrupted grant.

Verification
REQ-030 Single requester: req[0]=1, limit0=5, tick=1 -> grant=0001 next cycle; count 0..5; done[0] pulse 7 cycles after req sampled.
REQ-031 Contention: req=1111 held, all limits 2 -> grants in order 0,1,2,3,0; each done one cycle after its count reaches 2.
REQ-032 Gated tick: limit=3, tick toggling 1,0,1,0 -> count advances only on tick=1 cycles; done at the 3rd counted tick plus 1.
REQ-033 Abort: req[2] dropped at count=2 of limit 6 -> grant=0 next cycle, count=0, done stays 0; the next arbitration starts at index 3.
REQ-034 Edge cases: limit=0 -> done 2 cycles after req; limit=255 (WIDTH=8) -> count stops at 255, no rollover; abort while count==limit -> no done.
REQ-035 Reset mid-RUN: clr_n=0 at count=4 -> next cycle grant=0, count=0, busy=0; after release, index 0 wins first.
